// File: rtl/idct_x_da.sv
// idct_x_da: 8-point inverse DCT built around one multiply-accumulate.
// A block of eight signed coefficients is latched on accept. Each output
// sample is the sum of eight coefficient * weight products, taken one per
// cycle, then rounded, shifted down by the Q.12 weight scale and clamped
// to the signed output range. Samples leave one per output handshake.
module idct_x_da #(
  parameter int COEF_W = 18,
  parameter int ROM_W  = 14,
  parameter int ACC_W  = 36,
  parameter int OUT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [COEF_W-1:0] i_coef0,
  input  logic [COEF_W-1:0] i_coef1,
  input  logic [COEF_W-1:0] i_coef2,
  input  logic [COEF_W-1:0] i_coef3,
  input  logic [COEF_W-1:0] i_coef4,
  input  logic [COEF_W-1:0] i_coef5,
  input  logic [COEF_W-1:0] i_coef6,
  input  logic [COEF_W-1:0] i_coef7,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [OUT_W-1:0]  o_out_sample,
  output logic [2:0]        o_out_idx,
  output logic              o_out_last
);

  localparam int FRAC = 12;
  localparam int PW   = COEF_W + ROM_W;
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                    r_state;
  logic signed [COEF_W-1:0]  r_coef [8];
  logic [2:0]                r_n;
  logic [2:0]                r_k;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_out_valid;
  logic [OUT_W-1:0]          r_out_sample;
  logic [2:0]                r_out_idx;
  logic                      r_out_last;

  logic signed [ROM_W-1:0]   w_weight;
  logic signed [PW-1:0]      w_prod;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [ACC_W-1:0]   w_rnd;
  logic signed [ACC_W-1:0]   w_shift;
  logic [OUT_W-1:0]          w_sample;

  // Weight ROM, indexed {n,k}: round(4096 * a_k * cos((2n+1)k*pi/16)).
  always_comb begin
    w_weight = '0;
    case ({r_n, r_k})
      6'o00: w_weight = 14'sd1448;  6'o01: w_weight = 14'sd2009;  6'o02: w_weight = 14'sd1892;  6'o03: w_weight = 14'sd1703;
      6'o04: w_weight = 14'sd1448;  6'o05: w_weight = 14'sd1138;  6'o06: w_weight = 14'sd784;   6'o07: w_weight = 14'sd400;
      6'o10: w_weight = 14'sd1448;  6'o11: w_weight = 14'sd1703;  6'o12: w_weight = 14'sd784;   6'o13: w_weight = -14'sd400;
      6'o14: w_weight = -14'sd1448; 6'o15: w_weight = -14'sd2009; 6'o16: w_weight = -14'sd1892; 6'o17: w_weight = -14'sd1138;
      6'o20: w_weight = 14'sd1448;  6'o21: w_weight = 14'sd1138;  6'o22: w_weight = -14'sd784;  6'o23: w_weight = -14'sd2009;
      6'o24: w_weight = -14'sd1448; 6'o25: w_weight = 14'sd400;   6'o26: w_weight = 14'sd1892;  6'o27: w_weight = 14'sd1703;
      6'o30: w_weight = 14'sd1448;  6'o31: w_weight = 14'sd400;   6'o32: w_weight = -14'sd1892; 6'o33: w_weight = -14'sd1138;
      6'o34: w_weight = 14'sd1448;  6'o35: w_weight = 14'sd1703;  6'o36: w_weight = -14'sd784;  6'o37: w_weight = -14'sd2009;
      6'o40: w_weight = 14'sd1448;  6'o41: w_weight = -14'sd400;  6'o42: w_weight = -14'sd1892; 6'o43: w_weight = 14'sd1138;
      6'o44: w_weight = 14'sd1448;  6'o45: w_weight = -14'sd1703; 6'o46: w_weight = -14'sd784;  6'o47: w_weight = 14'sd2009;
      6'o50: w_weight = 14'sd1448;  6'o51: w_weight = -14'sd1138; 6'o52: w_weight = -14'sd784;  6'o53: w_weight = 14'sd2009;
      6'o54: w_weight = -14'sd1448; 6'o55: w_weight = -14'sd400;  6'o56: w_weight = 14'sd1892;  6'o57: w_weight = -14'sd1703;
      6'o60: w_weight = 14'sd1448;  6'o61: w_weight = -14'sd1703; 6'o62: w_weight = 14'sd784;   6'o63: w_weight = 14'sd400;
      6'o64: w_weight = -14'sd1448; 6'o65: w_weight = 14'sd2009;  6'o66: w_weight = -14'sd1892; 6'o67: w_weight = 14'sd1138;
      6'o70: w_weight = 14'sd1448;  6'o71: w_weight = -14'sd2009; 6'o72: w_weight = 14'sd1892;  6'o73: w_weight = -14'sd1703;
      6'o74: w_weight = 14'sd1448;  6'o75: w_weight = -14'sd1138; 6'o76: w_weight = 14'sd784;   6'o77: w_weight = -14'sd400;
      default: w_weight = '0;
    endcase
  end

  // Full-precision product, sign-extended into the accumulator, then the
  // round-half-up / floor shift that turns Q.12 back into sample units.
  assign w_prod     = r_coef[r_k] * w_weight;
  assign w_acc_next = r_acc + {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};
  assign w_rnd      = w_acc_next + RND;
  assign w_shift    = w_rnd >>> FRAC;

  // Clamp the shifted sum to the signed output range.
  always_comb begin
    w_sample = w_shift[OUT_W-1:0];
    if (w_shift > SAT_HI) begin
      w_sample = SAT_HI[OUT_W-1:0];
    end else if (w_shift < SAT_LO) begin
      w_sample = SAT_LO[OUT_W-1:0];
    end
  end

  // Control FSM: accept a block, run 8 MAC cycles per sample, hold each
  // sample until the sink takes it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      for (int i = 0; i < 8; i++) r_coef[i] <= '0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
      r_out_idx    <= '0;
      r_out_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_coef[0] <= i_coef0;
            r_coef[1] <= i_coef1;
            r_coef[2] <= i_coef2;
            r_coef[3] <= i_coef3;
            r_coef[4] <= i_coef4;
            r_coef[5] <= i_coef5;
            r_coef[6] <= i_coef6;
            r_coef[7] <= i_coef7;
            r_n       <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_state   <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 3'd1;
          if (r_k == 3'd7) begin
            r_out_sample <= w_sample;
            r_out_idx    <= r_n;
            r_out_last   <= (r_n == 3'd7);
            r_out_valid  <= 1'b1;
            r_state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (r_n == 3'd7) begin
              r_state <= S_IDLE;
            end else begin
              r_n     <= r_n + 3'd1;
              r_k     <= '0;
              r_acc   <= '0;
              r_state <= S_MAC;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready   = (r_state == S_IDLE);
  assign o_out_valid  = r_out_valid;
  assign o_out_sample = r_out_sample;
  assign o_out_idx    = r_out_idx;
  assign o_out_last   = r_out_last;

endmodule

// File: tb/tb_idct_x_da.sv
// Bench for idct_x_da: directed blocks plus random blocks; expected samples
// are queued at issue time and a monitor compares them at each handshake.
module tb_idct_x_da;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [17:0] c [8];
  logic        o_in_ready;
  logic        o_out_valid;
  logic [7:0]  o_out_sample;
  logic [2:0]  o_out_idx;
  logic        o_out_last;

  always #5 clk = ~clk;

  idct_x_da dut (
    .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_coef0(c[0]), .i_coef1(c[1]), .i_coef2(c[2]), .i_coef3(c[3]),
    .i_coef4(c[4]), .i_coef5(c[5]), .i_coef6(c[6]), .i_coef7(c[7]),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready), .o_out_sample(o_out_sample),
    .o_out_idx(o_out_idx), .o_out_last(o_out_last)
  );

  typedef struct {int idx; int smp;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wrom [8][8];
  int cur [8];
  int mode = 0;
  int bp = 0;
  int hs7_cyc = 0;
  int hs_cnt = 0;
  int acc_cyc = 0;
  int acc_cnt = 0;
  bit hold_v = 1'b0;
  int hold_s = 0;
  int hold_i = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int rom_entry(input int n, input int k);
    real a, v;
    a = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
    v = 4096.0 * a * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    if (v >= 0.0) return $rtoi($floor(v + 0.5));
    return -$rtoi($floor(-v + 0.5));
  endfunction

  function automatic int model(input int n);
    longint acc, r;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += longint'(cur[k]) * longint'(wrom[n][k]);
    r = (acc + 64'sd2048) >>> 12;
    if (r > 127) return 127;
    if (r < -128) return -128;
    return int'(r);
  endfunction

  task automatic push_model();
    for (int n = 0; n < 8; n++) exp_q.push_back('{n, model(n)});
  endtask

  task automatic push_const(input int v);
    for (int n = 0; n < 8; n++) exp_q.push_back('{n, v});
  endtask

  task automatic set_block(input int x0, input int x1);
    cur[0] = x0;
    cur[1] = x1;
    for (int k = 2; k < 8; k++) cur[k] = 0;
  endtask

  task automatic drive_coefs();
    for (int k = 0; k < 8; k++) c[k] = cur[k][17:0];
  endtask

  // Present cur[] and hold in_valid until the DUT takes it; returns #1
  // after the accepting edge.
  task automatic issue();
    int guard;
    drive_coefs();
    in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!o_in_ready && guard < 2000);
    if (!o_in_ready) chk("issue_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Sink ready: 0 = always ready, 1 = random, 2 = five stall cycles on sample 3.
  always @(posedge clk) begin
    #1;
    case (mode)
      1: out_ready = ($urandom_range(0, 7) != 0);
      2: begin
        if (o_out_valid && o_out_idx == 3'd3 && bp < 5) begin
          out_ready = 1'b0;
          bp++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Accept tracker: an accept seen mid-cycle happens on the next edge.
  always @(negedge clk) begin
    if (!reset && in_valid && o_in_ready) begin
      acc_cyc = cyc + 1;
      acc_cnt++;
    end
  end

  // Monitor: compare each handed-over sample; check stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", int'(o_out_valid), 1);
        chk("hold_sample", int'($signed(o_out_sample)), hold_s);
        chk("hold_idx", int'(o_out_idx), hold_i);
      end
      if (o_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample idx %0d sample %0d with nothing expected", o_out_idx, $signed(o_out_sample));
        end else begin
          e = exp_q.pop_front();
          chk("sample", int'($signed(o_out_sample)), e.smp);
          chk("idx", int'(o_out_idx), e.idx);
          chk("last", int'(o_out_last), int'(e.idx == 7));
        end
        if (o_out_idx == 3'd7) hs7_cyc = cyc + 1;
        hs_cnt++;
        hold_v = 1'b0;
      end else if (o_out_valid) begin
        hold_v = 1'b1;
        hold_s = int'($signed(o_out_sample));
        hold_i = int'(o_out_idx);
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    int base, guard;
    for (int k = 0; k < 8; k++) c[k] = '0;
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++) wrom[n][k] = rom_entry(n, k);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(o_out_valid), 0);
    chk("rst_out_sample", int'(o_out_sample), 0);
    chk("rst_out_idx", int'(o_out_idx), 0);
    chk("rst_out_last", int'(o_out_last), 0);
    chk("rst_in_ready", int'(o_in_ready), 1);
    chk("rom_w00", wrom[0][0], 1448);
    chk("rom_w01", wrom[0][1], 2009);
    chk("rom_w71", wrom[7][1], -2009);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // DC block with first-sample latency check.
    set_block(256, 0);
    push_const(91);
    issue();
    repeat (7) @(posedge clk);
    #1 chk("latency_t7_valid", int'(o_out_valid), 0);
    @(posedge clk);
    #1 chk("latency_t8_valid", int'(o_out_valid), 1);
    drain();

    set_block(-256, 0);
    push_const(-90);
    issue();
    drain();

    set_block(131071, 0);
    push_const(127);
    issue();
    drain();

    set_block(-131072, 0);
    push_const(-128);
    issue();
    drain();

    // First harmonic.
    set_block(0, 100);
    chk("model_h1_n0", model(0), 49);
    chk("model_h1_n7", model(7), -49);
    push_model();
    issue();
    drain();

    // Backpressure on sample 3.
    cur = '{300, -150, 80, 40, -20, 10, -5, 3};
    push_model();
    bp = 0;
    mode = 2;
    issue();
    drain();
    chk("bp_stall_cycles", bp, 5);
    mode = 0;

    // Reset during the MAC phase of sample 4.
    set_block(256, 0);
    push_const(91);
    base = hs_cnt;
    issue();
    guard = 0;
    while (hs_cnt < base + 4 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("reset_test_reached_s3", hs_cnt - base, 4);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    chk("midrst_out_valid", int'(o_out_valid), 0);
    chk("midrst_in_ready", int'(o_in_ready), 1);
    repeat (100) @(posedge clk);
    #1;
    set_block(256, 0);
    push_const(91);
    issue();
    drain();

    // Reset together with in_valid: the block must not be taken.
    set_block(-256, 0);
    drive_coefs();
    reset = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    chk("rst_vs_valid_in_ready", int'(o_in_ready), 1);
    repeat (100) @(posedge clk);
    #1;

    // Two blocks with in_valid held high.
    set_block(256, 0);
    push_const(91);
    drive_coefs();
    base = acc_cnt;
    in_valid = 1'b1;
    guard = 0;
    while (acc_cnt < base + 1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    set_block(-256, 0);
    push_const(-90);
    drive_coefs();
    guard = 0;
    while (acc_cnt < base + 2 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("b2b_accepts", acc_cnt - base, 2);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2b_gap", acc_cyc - hs7_cyc, 1);
    drain();

    // Random blocks with random sink stalls.
    mode = 1;
    for (int b = 0; b < 1000; b++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 9) == 0) cur[k] = int'($urandom_range(0, 262143)) - 131072;
        else cur[k] = int'($urandom_range(0, 400)) - 200;
      end
      push_model();
      issue();
    end
    drain();
    mode = 0;

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idct_x_da.md
Name: idct_x_da

Overview:
- Decoder-side counterpart of the DA forward-DCT coefficient units.
- Accepts one block of eight 18-bit signed DCT coefficients X0..X7, as produced by the encoder-side z-units.
- Reconstructs the eight 8-bit signed EEG samples x0..x7 with a single time-multiplexed multiply-accumulate and a coefficient ROM.
- Emits the samples one per handshake; sits between the RLE decoder output and the reconstructed-signal sink.

Parameters:
- COEF_W, 18, width of each input DCT coefficient (signed).
- ROM_W, 14, width of each IDCT weight (signed, Q.12).
- ACC_W, 36, accumulator width (signed).
- OUT_W, 8, reconstructed sample width (signed).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  coefficient block present on coef0..coef7.
- in_ready  output  1  block accepted when in_valid and in_ready are both high on a clk edge.
- coef0..coef7  input  COEF_W each  signed DCT coefficients X0..X7; sampled only on accept.
- out_valid  output  1  out_sample holds a valid reconstructed sample.
- out_ready  input  1  sink accepts the sample on a clk edge when out_valid is high.
- out_sample  output  OUT_W  signed reconstructed sample x_n.
- out_idx  output  3  sample index n (0..7) of out_sample.
- out_last  output  1  high with out_valid when n==7.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, n=0, k=0, acc=0.
  - Coefficient bank cleared to 0.
  - out_valid=0, out_sample=0, out_idx=0, out_last=0.
- in_ready is combinational, = (state==IDLE). It reads 1 after the first clk edge with reset high.
- Weight ROM, 64 entries indexed {n,k}:
  - W[n][k] = round(4096 * a_k * cos((2n+1)*k*pi/16)).
  - a_0 = 1/sqrt(8); a_k = 1/2 for k>0.
  - round is half away from zero. Examples: W[n][0]=1448; W[0][1]=2009; W[7][1]=-2009.
  - Contents are generated offline and written as constants; the ROM is combinational.
- FSM states IDLE, MAC, OUT.
- IDLE:
  - On accept: latch coef0..coef7, set n=0, k=0, acc=0, go to MAC.
- MAC:
  - Each cycle: acc <= acc + coef[k]*W[n][k]. The full signed product is sign-extended to ACC_W; no intermediate truncation.
  - k increments each cycle.
  - After the k=7 term: out_sample <= sat((acc_final + 2048) >>> 12), go to OUT.
  - sat clamps to [-128, 127]. >>> is an arithmetic shift (floor).
  - Exactly 8 MAC cycles per sample.
- OUT:
  - out_valid=1; out_sample, out_idx and out_last are held stable until handshake.
  - On handshake with n<7: n++, k=0, acc=0, out_valid=0, go to MAC.
  - On handshake with n==7: out_valid=0, go to IDLE.
- Latency:
  - Accept at edge t gives sample 0 valid after edge t+8.
  - With out_ready held high, each subsequent sample follows 9 cycles after the previous handshake edge.
  - Full block: 72 cycles accept-to-last-handshake.
- Backpressure: out_ready low holds OUT indefinitely; no sample is lost or altered.
- Back-to-back blocks: in_ready returns high the cycle after the n==7 handshake, so the next block is accepted at the earliest one cycle later.
- The coefficient bank is never modified outside accept; input changes while busy are ignored.
- in_valid while not in IDLE: ignored; the upstream block must hold its data until in_ready.
- Reset mid-operation, in any state: on that edge return to reset values, discard the partial block, emit no further samples.
- Simultaneous reset and in_valid: reset wins; the block is not accepted.

Test Plan:
- DC only: X0=256, others 0 -> eight samples, each 91, out_idx 0..7, out_last only on idx 7; first out_valid 8 cycles after accept.
- Negative DC with rounding: X0=-256 -> all samples -90.
- First harmonic: X1=100, others 0 -> sample 0 = 49 and sample 7 = -49, checked against the bit-exact model using the ROM formula; remaining samples also match the model.
- Saturation: X0=131071 -> all 127. X0=-131072 -> all -128.
- Backpressure: out_ready low for 5 cycles while sample 3 is valid -> out_sample and out_idx stable throughout, sample 4 follows correctly, no skipped indices. Run with random out_ready over 1000 random blocks and compare every sample to the model.
- Reset and throughput:
  - Assert reset for 1 cycle during sample 4 MAC -> out_valid 0 next cycle, in_ready 1, no further samples; a new block X0=256 then yields eight 91s.
  - in_valid held high with two blocks -> second block accepted exactly one cycle after the first block's idx-7 handshake.
